// File: rtl/i2c_pkg.sv
// i2c_pkg
// Shared definitions for the I2C target register file and any later bus
// monitors built on the same synchroniser.
//   - i2c_tgt_state_e : protocol state of the target engine
//   - I2C_ADDR_W      : width of a 7-bit bus address
//   - I2C_BYTE_W      : width of one bus byte
//   - RW_READ/RW_WRITE: value of the R/W bit that follows the address
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // IGNORE parks the engine after an address miss, a bad pointer or a
  // master NACK until the next START or STOP.
  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_tgt_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync
// Brings the raw SCL/SDA pin levels into the clk domain and derives the
// bus events that the protocol engines act upon.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   scl_i, sda_i: raw pin levels
//   sda         : synchronised SDA level
//   scl_rise    : one-clk pulse on a synchronised SCL rising edge
//   scl_fall    : one-clk pulse on a synchronised SCL falling edge
//   start_det   : one-clk pulse when SDA falls while SCL is high
//   stop_det    : one-clk pulse when SDA rises while SCL is high
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl;

  // Synchroniser chains plus one history flop per line for edge detection.
  // Everything resets to 1 so that an idle, pulled-up bus produces no
  // spurious edge when reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_i};
      sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_i};
      scl_prev <= scl_pipe[SYNC_STAGES-1];
      sda_prev <= sda_pipe[SYNC_STAGES-1];
    end
  end

  assign scl = scl_pipe[SYNC_STAGES-1];
  assign sda = sda_pipe[SYNC_STAGES-1];

  assign scl_rise = scl & ~scl_prev;
  assign scl_fall = ~scl & scl_prev;

  // SCL must be high in both samples so an SDA change that coincides with
  // an SCL edge is never taken as a bus condition.
  assign start_det = scl & scl_prev & sda_prev & ~sda;
  assign stop_det  = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile
// I2C target with a DEPTH x 8-bit register file. A write transfer carries
// a pointer byte followed by data bytes; a read transfer returns bytes from
// the current pointer. The pointer optionally auto-increments with wrap.
// Ports:
//   clk, rst_n : system clock (>= 8x SCL), asynchronous active-low reset
//   scl_i/sda_i: raw pin levels from the open-drain pads
//   sda_oe     : 1 pulls SDA low (ACK or a 0 data bit), 0 releases
//   busy       : high from START to STOP
//   wr_valid   : one-clk pulse per accepted write byte
//   wr_ptr     : register index of that write
//   wr_data    : byte written
//   tap_ptr    : local read index
//   tap_data   : combinational mem[tap_ptr]
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
  parameter int                    DEPTH       = 16,
  parameter bit                    AUTO_INC    = 1'b1,
  parameter int                    SYNC_STAGES = 2,
  localparam int                   PTR_W       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic                  busy,
  output logic                  wr_valid,
  output logic [PTR_W-1:0]      wr_ptr,
  output logic [I2C_BYTE_W-1:0] wr_data,
  input  logic [PTR_W-1:0]      tap_ptr,
  output logic [I2C_BYTE_W-1:0] tap_data
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_tgt_state_e state, state_next;

  logic [2:0]            bit_cnt, bit_cnt_next;
  logic [6:0]            shift, shift_next;
  logic [PTR_W-1:0]      ptr, ptr_next, ptr_inc;
  logic                  rw, rw_next;
  logic                  sda_oe_next;
  logic                  busy_next;
  logic                  wr_valid_next;
  logic [PTR_W-1:0]      wr_ptr_next;
  logic [I2C_BYTE_W-1:0] wr_data_next;
  logic                  mem_we;

  logic [I2C_BYTE_W-1:0] mem [DEPTH];

  logic [I2C_BYTE_W-1:0] rx_byte;
  logic                  last_bit;
  logic                  addr_match;
  logic                  ptr_ok;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  // The byte as it stands once the bit on the current SCL rise is included,
  // so decisions on the 8th bit need no extra cycle.
  assign rx_byte    = {shift, sda_s};
  assign last_bit   = (bit_cnt == 3'd0);
  assign addr_match = (rx_byte[I2C_BYTE_W-1:1] == TARGET_ADDR);
  assign ptr_ok     = (int'(rx_byte) < DEPTH);

  assign tap_data = mem[tap_ptr];

  // Pointer value after a completed data byte: wrap at the top of the
  // register file, or hold when auto-increment is disabled.
  always_comb begin
    ptr_inc = ptr;
    if (AUTO_INC) begin
      ptr_inc = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Bus conditions win over bit processing; all other
  // transitions happen on the SCL rise that samples a bit, so each state's
  // SCL fall action applies to the bit slot that follows.
  always_comb begin
    state_next = state;
    if (stop_det) begin
      state_next = IDLE;
    end else if (start_det) begin
      state_next = ADDR;
    end else if (scl_rise) begin
      case (state)
        ADDR:      if (last_bit) state_next = addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK:  state_next = (rw == RW_READ) ? RDATA : PTR;
        PTR:       if (last_bit) state_next = ptr_ok ? PTR_ACK : IGNORE;
        PTR_ACK:   state_next = WDATA;
        WDATA:     if (last_bit) state_next = WDATA_ACK;
        WDATA_ACK: state_next = WDATA;
        RDATA:     if (last_bit) state_next = RDATA_ACK;
        RDATA_ACK: state_next = sda_s ? IGNORE : RDATA;
        default:   state_next = state;
      endcase
    end
  end

  // Output and datapath next values. Bits are taken on SCL rise; the SDA
  // drive is only updated on SCL fall, so the line is stable while the
  // master samples it. ACK states pull low for the whole 9th clock, RDATA
  // drives the inverted data bit, every other state releases.
  always_comb begin
    bit_cnt_next  = bit_cnt;
    shift_next    = shift;
    ptr_next      = ptr;
    rw_next       = rw;
    sda_oe_next   = sda_oe;
    busy_next     = busy;
    wr_valid_next = 1'b0;
    wr_ptr_next   = wr_ptr;
    wr_data_next  = wr_data;
    mem_we        = 1'b0;

    if (stop_det) begin
      sda_oe_next = 1'b0;
      busy_next   = 1'b0;
    end else if (start_det) begin
      busy_next    = 1'b1;
      bit_cnt_next = 3'd7;
    end else if (scl_rise) begin
      case (state)
        ADDR, PTR, WDATA: begin
          shift_next   = rx_byte[6:0];
          bit_cnt_next = bit_cnt - 3'd1;
        end
        RDATA: begin
          bit_cnt_next = bit_cnt - 3'd1;
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK, RDATA_ACK: begin
          bit_cnt_next = 3'd7;
        end
        default: begin
          bit_cnt_next = bit_cnt;
        end
      endcase

      if (state == ADDR && last_bit) begin
        rw_next = sda_s;
      end

      if (state == PTR && last_bit && ptr_ok) begin
        ptr_next = rx_byte[PTR_W-1:0];
      end

      // A byte is only committed on its 8th bit, so a START part-way
      // through leaves the register file untouched.
      if (state == WDATA && last_bit) begin
        mem_we        = 1'b1;
        wr_valid_next = 1'b1;
        wr_ptr_next   = ptr;
        wr_data_next  = rx_byte;
        ptr_next      = ptr_inc;
      end

      if (state == RDATA_ACK && !sda_s) begin
        ptr_next = ptr_inc;
      end
    end else if (scl_fall) begin
      case (state)
        ADDR_ACK, PTR_ACK, WDATA_ACK: sda_oe_next = 1'b1;
        RDATA:                        sda_oe_next = ~mem[ptr][bit_cnt];
        default:                      sda_oe_next = 1'b0;
      endcase
    end
  end

  // Datapath, outputs and register file. The tap reads the stored array,
  // so a same-clk bus write becomes visible on the tap one clk later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 3'd7;
      shift    <= '0;
      ptr      <= '0;
      rw       <= RW_WRITE;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_ptr   <= '0;
      wr_data  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      bit_cnt  <= bit_cnt_next;
      shift    <= shift_next;
      ptr      <= ptr_next;
      rw       <= rw_next;
      sda_oe   <= sda_oe_next;
      busy     <= busy_next;
      wr_valid <= wr_valid_next;
      wr_ptr   <= wr_ptr_next;
      wr_data  <= wr_data_next;
      if (mem_we) begin
        mem[ptr] <= rx_byte;
      end
    end
  end

endmodule
